serial_adder_arbiter: RTL and testbench
=======================================

# serial_adder_arbiter

Bit-serial N-bit adder that time-shares a single full-adder cell between two requesters. A round-robin arbiter picks one requester. The controller loads that requester's operands and steps them LSB-first through the one full adder, one bit per clock, with a registered carry. It then returns the sum, carry-out and signed overflow over a valid/ready response port. The block trades latency for area and sits wherever several clients need occasional additions and a parallel adder per client is not justified.

## Interface
- WIDTH, 8: operand/result width in bits; legal values are WIDTH >= 2.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 is granted this cycle; an operation is accepted when valid && ready.
- req0_a, req0_b  in  WIDTH each  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same meanings for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result when resp_valid && resp_ready.
- resp_id  out  1  index of the requester that issued the result.
- resp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- resp_cout  out  1  carry out of bit WIDTH-1.
- resp_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in SHIFT and DONE.

## Operation
- Exactly one full-adder instance exists (sum = a^b^cin, cout = a&b | (a^b)&cin). It is fed by the LSBs of the operand shift registers and a carry flip-flop. No other adder is permitted.
- The FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - req*_ready is combinational from state, both valids and last_grant.
  - Only one valid: that requester gets ready.
  - Both valid: the requester not equal to last_grant gets ready.
  - No valid: both ready signals are 0.
  - At most one ready is ever high.
- Accept (valid && ready in IDLE):
  - Latch a and b into the shift registers and cin into the carry flip-flop.
  - Set id and last_grant to the granted index.
  - Clear the bit counter and go to SHIFT.
- SHIFT, each cycle:
  - Shift the full-adder sum into the result register at the MSB, shifting the register right.
  - Shift both operand registers right.
  - Load the full-adder cout into the carry flip-flop.
  - At bit WIDTH-1, also capture the carry-in of that bit (for the overflow computation).
  - Increment the counter.
  - After the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - resp_valid = 1; resp_id, resp_sum, resp_cout and resp_ovf are held stable.
  - On resp_valid && resp_ready, go to IDLE.
- Requesters may change or withdraw valid at any time before acceptance. Arbitration is re-evaluated every IDLE cycle.
- Operand inputs are sampled only on the accept edge. Later changes have no effect on the operation in progress.

## Timing
- On reset, and while reset is high, every output is 0:
  - req0_ready = req1_ready = 0
  - resp_valid = 0, resp_id = 0, resp_sum = 0, resp_cout = 0, resp_ovf = 0, busy = 0
- On reset, state = IDLE and last_grant = 1, so requester 0 wins the first contention.
- Reset mid-operation discards the operation. No response is produced for it.
- Latency: resp_valid rises exactly WIDTH cycles after the accept edge (the accept edge is E0; resp_valid is high after edge E_WIDTH).
- Throughput: with resp_ready held high, accepts are WIDTH+2 cycles apart.
  - WIDTH SHIFT cycles, plus 1 DONE cycle, plus 1 IDLE cycle.
  - No acceptance occurs in SHIFT or DONE.
- Backpressure: DONE holds indefinitely. Both ready signals stay 0 and the response outputs do not change.
- Carry wrap: resp_cout carries the bit dropped from the WIDTH-bit sum; resp_sum wraps modulo 2^WIDTH.

## Test plan
- Reset: assert reset mid-test -> all outputs 0 on the same cycle without waiting for a clock edge; after release with both valids high, req0_ready = 1 and req1_ready = 0.
- Single op, WIDTH=8: req0 a=0x3C, b=0x0F, cin=0 -> resp_sum=0x4B, cout=0, ovf=0, id=0; resp_valid rises exactly 8 cycles after the accept edge.
- Arithmetic corners:
  - 0xFF+0x01, cin=0 -> 0x00, cout=1, ovf=0
  - 0x7F+0x01, cin=0 -> 0x80, cout=0, ovf=1
  - 0x80+0x80, cin=1 -> 0x01, cout=1, ovf=1
  - 0x00+0x00, cin=1 -> 0x01, cout=0, ovf=0
- Contention: both valids held high with resp_ready=1 for 6 operations -> grants and resp_id alternate 0,1,0,1,0,1; accepts are 10 cycles apart.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE with req1_valid=1 -> response held stable, req1_ready stays 0; acceptance of req1 occurs 1 cycle after resp_ready rises.
- Reset at bit 3 of a SHIFT from requester 1, with req0 a=0x10, b=0x20 pending -> no response for the aborted operation; after release, req0 is accepted first and returns resp_sum=0x30, id=0.

Source files
------------

// File: rtl/serial_adder_arbiter.sv
// Round-robin shared bit-serial adder: one full-adder cell, LSB-first, result WIDTH cycles after accept.
// Response waits in DONE until resp_ready; no new request is granted until the result is taken.
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             grant0;
    logic             grant1;
    logic             fa_sum;
    logic             fa_cout;

    // The only adder in the block: fed by the operand LSBs and the carry flop.
    assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_cout = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        cmsb_d       = cmsb_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    carry_d      = grant1 ? req1_cin : req0_cin;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                // Carry into the MSB is kept so overflow can be formed after the last bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cmsb_d  = carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            cmsb_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            cmsb_q       <= cmsb_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = carry_q;
    assign resp_ovf   = cmsb_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Directed bench for serial_adder_arbiter with hand-computed expected results.
module tb_serial_adder_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_cout, resp_ovf, busy;
    logic [W-1:0] resp_sum;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] CA [4]   = '{8'hFF, 8'h7F, 8'h80, 8'h00};
    localparam logic [7:0] CB [4]   = '{8'h01, 8'h01, 8'h80, 8'h00};
    localparam logic       CC [4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [7:0] CS [4]   = '{8'h00, 8'h80, 8'h01, 8'h01};
    localparam logic       CCO [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic       COV [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

    serial_adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_cout, resp_ovf, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b expected 0000000",
                     {req0_ready, req1_ready, resp_valid, resp_id, resp_cout, resp_ovf, busy});
        end
        n_vec++;
        if (resp_sum !== 8'h00) begin
            n_err++; $display("FAIL reset_sum: got %h expected 00", resp_sum);
        end
        step(); step();
        n_vec++;
        if ({req0_ready, req1_ready, resp_valid, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected 0000", {req0_ready, req1_ready, resp_valid, busy});
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        int lat;
        req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'hFF; req0_cin = 1'b1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL single_busy: got %b expected 1", busy);
        end
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        n_vec++;
        if (lat !== 8) begin
            n_err++; $display("FAIL single_latency: got %0d expected 8", lat);
        end
        n_vec++;
        if ({resp_sum, resp_cout, resp_ovf, resp_id} !== {8'h4B, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_result: got sum=%h cout=%b ovf=%b id=%b expected sum=4b cout=0 ovf=0 id=0",
                     resp_sum, resp_cout, resp_ovf, resp_id);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_release: got valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_corners();
        int lat;
        logic use1;
        for (int i = 0; i < 4; i++) begin
            use1 = (i % 2) == 0;
            if (use1) begin
                req1_a = CA[i]; req1_b = CB[i]; req1_cin = CC[i]; req1_valid = 1'b1;
            end else begin
                req0_a = CA[i]; req0_b = CB[i]; req0_cin = CC[i]; req0_valid = 1'b1;
            end
            #1;
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            lat = 0;
            while (!resp_valid && lat < 20) begin
                step();
                lat++;
            end
            n_vec++;
            if ({resp_sum, resp_cout, resp_ovf, resp_id} !== {CS[i], CCO[i], COV[i], use1}) begin
                n_err++;
                $display("FAIL corner_%0d: got sum=%h cout=%b ovf=%b id=%b expected sum=%h cout=%b ovf=%b id=%b",
                         i, resp_sum, resp_cout, resp_ovf, resp_id, CS[i], CCO[i], COV[i], use1);
            end
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_contention();
        int g_id[$];
        int g_t[$];
        int r_id[$];
        int c;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req0_a = 8'h11; req0_b = 8'h22; req0_cin = 1'b0;
        req1_a = 8'h40; req1_b = 8'h05; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        c = 0;
        while ((g_id.size() < 6 || r_id.size() < 6) && c < 150) begin
            if (req0_ready && req1_ready) begin
                n_vec++; n_err++;
                $display("FAIL contention_onehot: got both ready at cycle %0d expected at most one", c);
            end
            if (req0_ready || req1_ready) begin
                g_id.push_back(int'(req1_ready));
                g_t.push_back(c);
            end
            if (resp_valid) begin
                r_id.push_back(int'(resp_id));
                n_vec++;
                if (resp_sum !== (resp_id ? 8'h46 : 8'h33)) begin
                    n_err++;
                    $display("FAIL contention_sum: got %h for id %b expected %h",
                             resp_sum, resp_id, resp_id ? 8'h46 : 8'h33);
                end
            end
            if (g_id.size() < 6 || r_id.size() < 6) begin
                step();
                c++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_vec++;
        if (g_id.size() != 6 || r_id.size() != 6) begin
            n_err++;
            $display("FAIL contention_count: got grants=%0d resps=%0d expected 6 6", g_id.size(), r_id.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < g_id.size() && i < r_id.size()) begin
                n_vec++;
                if (g_id[i] != i % 2 || r_id[i] != i % 2) begin
                    n_err++;
                    $display("FAIL contention_order_%0d: got grant=%0d id=%0d expected %0d", i, g_id[i], r_id[i], i % 2);
                end
            end
            if (i > 0 && i < g_t.size()) begin
                n_vec++;
                if (g_t[i] - g_t[i-1] != 10) begin
                    n_err++;
                    $display("FAIL contention_gap_%0d: got %0d expected 10", i, g_t[i] - g_t[i-1]);
                end
            end
        end
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        req1_a = 8'h05; req1_b = 8'h06; req1_cin = 1'b0; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({resp_valid, resp_sum, resp_id, req0_ready, req1_ready} !== {1'b1, 8'h03, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got valid=%b sum=%h id=%b r0=%b r1=%b expected 1 03 0 0 0",
                         k, resp_valid, resp_sum, resp_id, req0_ready, req1_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b r1=%b expected 0 1", resp_valid, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL bp_accept: got busy=%b expected 1", busy);
        end
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        n_vec++;
        if ({resp_valid, resp_sum, resp_id} !== {1'b1, 8'h0B, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second: got valid=%b sum=%h id=%b expected 1 0b 1", resp_valid, resp_sum, resp_id);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        req1_a = 8'h0F; req1_b = 8'h01; req1_cin = 1'b0; req1_valid = 1'b1;
        #1;
        step();
        req1_valid = 1'b0;
        step(); step(); step();
        req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL midrst_busy: got r0=%b busy=%b expected 0 1", req0_ready, busy);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_cout, resp_ovf, busy, resp_sum} !== 15'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %b expected all 0",
                     {req0_ready, req1_ready, resp_valid, resp_id, resp_cout, resp_ovf, busy, resp_sum});
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_grant: got %b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        n_vec++;
        if (lat !== 8 || resp_sum !== 8'h30 || resp_id !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_result: got lat=%0d sum=%h id=%b expected 8 30 0", lat, resp_sum, resp_id);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
